// File: rtl/lut_layer_sched.sv
// Time-multiplexed LUT-neuron layer: one shared truth-table RAM, neurons sequenced one per cycle.
// Optional macro LUT_SCHED_PARITY_EN adds an even-parity bit per table entry and a sticky par_err.
module lut_layer_sched #(
    parameter int IN_BITS     = 2,
    parameter int FAN_IN      = 4,
    parameter int OUT_BITS    = 2,
    parameter int NUM_IN      = 64,
    parameter int NUM_NEURONS = 64,
    localparam int AW    = FAN_IN * IN_BITS,
    localparam int IDX_W = $clog2(NUM_IN),
    localparam int NW    = $clog2(NUM_NEURONS),
    localparam int CW    = (OUT_BITS > IDX_W) ? OUT_BITS : IDX_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_IN*IN_BITS-1:0]       in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_we,
    input  logic                            cfg_sel,
    input  logic [NW+AW-1:0]                cfg_addr,
    input  logic [CW-1:0]                   cfg_wdata,
    output logic                            cfg_ready,
    output logic                            par_err
);
    localparam int SW = $clog2(FAN_IN);
    localparam int TD = 1 << (NW + AW);
    localparam int CD = 1 << NW;
    localparam logic [NW-1:0] LAST_N = NW'(NUM_NEURONS - 1);
`ifdef LUT_SCHED_PARITY_EN
    localparam int TW = OUT_BITS + 1;
`else
    localparam int TW = OUT_BITS;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_OUT} state_t;

    state_t                state, state_nxt;
    logic                  accept, cfg_ok, issue_on;
    logic [NW-1:0]         cnt;
    logic                  vld_p0, vld_p1;
    logic [NW-1:0]         n_p0, n_p1;
    logic [IDX_W-1:0]      conn_mem [CD][FAN_IN];
    logic [IDX_W-1:0]      conn_p0 [FAN_IN];
    logic [IN_BITS-1:0]    act_q [NUM_IN];
    logic [AW-1:0]         lut_addr;
    logic [TW-1:0]         tab_mem [TD];
    logic [TW-1:0]         tab_p1;
    logic [OUT_BITS-1:0]   out_q [NUM_NEURONS];

    function automatic logic [TW-1:0] tab_word(input logic [OUT_BITS-1:0] d);
`ifdef LUT_SCHED_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign in_ready  = (state == ST_IDLE);
    assign cfg_ready = (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign accept    = in_valid && in_ready;
    assign cfg_ok    = cfg_we && cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_EVAL;
            ST_EVAL: if (vld_p1 && (n_p1 == LAST_N)) state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Issue counter stops on the last neuron instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            issue_on <= 1'b0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p0 <= issue_on;
            vld_p1 <= vld_p0;
            if (accept) begin
                cnt      <= '0;
                issue_on <= 1'b1;
            end else if (issue_on) begin
                if (cnt == LAST_N) issue_on <= 1'b0;
                else               cnt      <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            for (int k = 0; k < NUM_IN; k++)
                act_q[k] <= in_data[k*IN_BITS +: IN_BITS];
    end

    // S0: connectivity read
    always_ff @(posedge clk) begin
        if (cfg_ok && cfg_sel)
            conn_mem[cfg_addr[SW +: NW]][cfg_addr[SW-1:0]] <= cfg_wdata[IDX_W-1:0];
        conn_p0 <= conn_mem[cnt];
        n_p0    <= cnt;
    end

    // S1: gather; an index with no matching input leaves its field at zero
    always_comb begin
        lut_addr = '0;
        for (int s = 0; s < FAN_IN; s++)
            for (int k = 0; k < NUM_IN; k++)
                if (conn_p0[s] == IDX_W'(k))
                    lut_addr[s*IN_BITS +: IN_BITS] = act_q[k];
    end

    always_ff @(posedge clk) begin
        if (cfg_ok && !cfg_sel)
            tab_mem[cfg_addr] <= tab_word(cfg_wdata[OUT_BITS-1:0]);
        tab_p1 <= tab_mem[{n_p0, lut_addr}];
        n_p1   <= n_p0;
    end

    // S2: store result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NEURONS; n++) out_q[n] <= '0;
        end else if (vld_p1) begin
            out_q[n_p1] <= tab_p1[OUT_BITS-1:0];
        end
    end

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_out
        assign out_data[g*OUT_BITS +: OUT_BITS] = out_q[g];
    end

`ifdef LUT_SCHED_PARITY_EN
    logic par_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  par_err_q <= 1'b0;
        else if (vld_p1 && ^tab_p1)  par_err_q <= 1'b1;
    end
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_lut_layer_sched.sv
// Randomized bench for lut_layer_sched against an array-based layer model.
module tb_lut_layer_sched;
    localparam int NUM_IN = 48;
    localparam int NUM_NEURONS = 64;
    localparam int DW = NUM_IN * 2;
    localparam int OW = NUM_NEURONS * 2;

    logic          clk, rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [OW-1:0] out_data;
    logic          cfg_we, cfg_sel, cfg_ready, par_err;
    logic [13:0]   cfg_addr;
    logic [5:0]    cfg_wdata;

    lut_layer_sched #(.IN_BITS(2), .FAN_IN(4), .OUT_BITS(2), .NUM_IN(NUM_IN),
                      .NUM_NEURONS(NUM_NEURONS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
        .par_err(par_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int t_cap;

    int         conn_m [NUM_NEURONS][4];
    logic [1:0] tab_m  [NUM_NEURONS][256];
    logic [1:0] act_m  [NUM_IN];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_out();
        logic [127:0] v;
        int a, idx;
        v = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            a = 0;
            for (int s = 0; s < 4; s++) begin
                idx = conn_m[n][s];
                if (idx < NUM_IN) a = a + (int'(act_m[idx]) << (2 * s));
            end
            v[n*2 +: 2] = tab_m[n][a];
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_act();
        logic [DW-1:0] d;
        for (int k = 0; k < NUM_IN; k++) d[k*2 +: 2] = 2'($urandom_range(3));
        return d;
    endfunction

    task automatic cfg_wr(input logic sel, input int addr, input int data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr[13:0]; cfg_wdata = data[5:0];
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic tab_wr(input int n, input int a, input int d);
        cfg_wr(1'b0, n * 256 + a, d);
        tab_m[n][a] = d[1:0];
    endtask

    task automatic conn_wr(input int n, input int s, input int idx);
        cfg_wr(1'b1, n * 4 + s, idx);
        conn_m[n][s] = idx;
    endtask

    task automatic start_frame(input logic [DW-1:0] d);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin @(negedge clk); w++; end
        check("in_ready_wait", in_ready, 1);
        in_data = d; in_valid = 1'b1;
        for (int k = 0; k < NUM_IN; k++) act_m[k] = d[k*2 +: 2];
        @(posedge clk); #1;
        t_cap = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        while (!out_valid && (cyc - t_cap) < 300) begin @(posedge clk); #1; end
        check({tag, "_lat"}, cyc - t_cap, NUM_NEURONS + 2);
        check({tag, "_data"}, out_data, model_out());
    endtask

    task automatic release_out(input string tag);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    task automatic do_frame(input logic [DW-1:0] d, input string tag);
        start_frame(d);
        wait_out(tag);
        release_out(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [127:0]  snap;
        int j;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_ready", {in_ready, cfg_ready, out_valid, par_err}, 4'b1100);
        check("rst_data", out_data, '0);
        @(negedge clk); rst_n = 1'b1;

        // identity layer
        for (int n = 0; n < NUM_NEURONS; n++)
            for (int s = 0; s < 4; s++) conn_wr(n, s, n);
        for (int n = 0; n < NUM_NEURONS; n++)
            for (int a = 0; a < 256; a++) tab_wr(n, a, a % 4);
        for (int k = 0; k < NUM_IN; k++) d[k*2 +: 2] = 2'(k % 4);
        start_frame(d);
        wait_out("t1");
        check("t1_slot7", out_data[15:14], 2'd3);
        check("t1_slot50", out_data[101:100], 2'd0);
        release_out("t1");

        // neuron 5 detects pattern 0x30
        for (int s = 0; s < 4; s++) conn_wr(5, s, s);
        for (int a = 0; a < 256; a++) tab_wr(5, a, (a == 'h30) ? 0 : 1);
        d = rand_act(); d[7:0] = 8'b00_11_00_00;
        start_frame(d);
        wait_out("t2a");
        check("t2a_slot5", out_data[11:10], 2'b00);
        release_out("t2a");
        d[5:4] = 2'd2;
        start_frame(d);
        wait_out("t2b");
        check("t2b_slot5", out_data[11:10], 2'b01);

        // backpressure hold
        release_out("t2b");
        start_frame(rand_act());
        wait_out("t3");
        snap = model_out();
        repeat (20) begin
            @(posedge clk); #1;
            check("t3_hold", {out_valid, in_ready}, 2'b10);
            check("t3_stable", out_data, snap);
        end
        release_out("t3");
        do_frame(rand_act(), "t3_next");

        // config write during EVAL is dropped
        d = rand_act(); d[7:0] = 8'b00_11_00_00;
        start_frame(d);
        repeat (3) @(negedge clk);
        check("t4_cfg_busy", cfg_ready, 1'b0);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 14'(5 * 256 + 'h30); cfg_wdata = 6'd3;
        @(negedge clk); cfg_we = 1'b0;
        wait_out("t4a");
        release_out("t4a");
        start_frame(d);
        wait_out("t4b");
        check("t4b_slot5", out_data[11:10], 2'b00);
        release_out("t4b");

        // out-of-range indices read as zero
        for (int a = 0; a < 256; a++) tab_wr(10, a, a % 4);
        conn_wr(10, 0, 50); conn_wr(10, 1, 63); conn_wr(10, 2, 0); conn_wr(10, 3, 47);
        d = '1;
        start_frame(d);
        wait_out("t5");
        check("t5_slot10", out_data[21:20], 2'b00);
        release_out("t5");

        // reset mid-frame
        start_frame(rand_act());
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_ctl", {out_valid, in_ready, cfg_ready}, 3'b011);
        check("t5_rst_data", out_data, '0);
        @(negedge clk); rst_n = 1'b1;
        do_frame(rand_act(), "t5_after");

        // config write coinciding with frame accept
        d = rand_act();
        j = $urandom_range(NUM_IN - 1);
        @(negedge clk);
        in_data = d; in_valid = 1'b1;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 14'd0; cfg_wdata = 6'(j);
        conn_m[0][0] = j;
        for (int k = 0; k < NUM_IN; k++) act_m[k] = d[k*2 +: 2];
        @(posedge clk); #1;
        t_cap = cyc;
        in_valid = 1'b0; cfg_we = 1'b0;
        wait_out("t_coin");
        release_out("t_coin");

        // random reconfiguration and frames
        for (int f = 0; f < 6; f++) begin
            repeat (8) conn_wr($urandom_range(NUM_NEURONS - 1), $urandom_range(3), $urandom_range(63));
            repeat (24) tab_wr($urandom_range(NUM_NEURONS - 1), $urandom_range(255), $urandom_range(3));
            do_frame(rand_act(), "rnd");
        end

`ifdef LUT_SCHED_PARITY_EN
        dut.tab_mem[3 * 256][0] = ~dut.tab_mem[3 * 256][0];
        tab_m[3][0] = tab_m[3][0] ^ 2'b01;
        do_frame('0, "par");
        check("par_set", par_err, 1'b1);
        do_frame(rand_act(), "par2");
        check("par_sticky", par_err, 1'b1);
`else
        do_frame('0, "nopar");
        check("par_zero", par_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
